// File: rtl/tdc_pkg.sv
// tdc_pkg: shared widths and timestamp field layout for the TDC channel.
//   fine_w(n)      : FINE field width, enough to hold 0..n taps
//   ts_w(n, c)     : total timestamp width {SAT, COARSE, FINE}
//   *_lsb / sat_bit: field positions inside the timestamp word
//   DROP_CNT_W     : width of the saturating drop counter
package tdc_pkg;

    localparam int DROP_CNT_W = 8;
    localparam int FINE_LSB   = 0;

    function automatic int fine_w(input int n_taps);
        return $clog2(n_taps + 1);
    endfunction

    function automatic int ts_w(input int n_taps, input int coarse_w);
        return 1 + coarse_w + fine_w(n_taps);
    endfunction

    function automatic int coarse_lsb(input int n_taps);
        return fine_w(n_taps);
    endfunction

    function automatic int sat_bit(input int n_taps, input int coarse_w);
        return fine_w(n_taps) + coarse_w;
    endfunction

endpackage

// File: rtl/tdc_thermo_encoder.sv
// tdc_thermo_encoder: registered thermometer-to-binary encoder for the
// synchronised delay-line word.
// Optional macro: BUBBLE_FIX_EN -- when defined, a 3-tap majority filter
// removes single-bit bubbles and FINE is the popcount of the filtered word;
// otherwise FINE is the number of leading ones from bit 0.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   s2_i   : synchronised tap word (bit 0 nearest the hit)
//   sat_o  : registered, set when the whole line reads as ones
//   fine_o : registered fine time
module tdc_thermo_encoder
    import tdc_pkg::*;
#(
    parameter int N_TAPS = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_TAPS-1:0]         s2_i,
    output logic                      sat_o,
    output logic [fine_w(N_TAPS)-1:0] fine_o
);

    localparam int FINE_W = fine_w(N_TAPS);

    logic [FINE_W-1:0] fine_d;
    logic              sat_d;

`ifdef BUBBLE_FIX_EN
    logic [N_TAPS-1:0] filt;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_comb begin
        filt = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            // end taps replicate themselves as the missing neighbour
            filt[i] = maj3((i == 0)          ? s2_i[0]        : s2_i[i-1],
                           s2_i[i],
                           (i == N_TAPS - 1) ? s2_i[N_TAPS-1] : s2_i[i+1]);
        end
        fine_d = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            fine_d = fine_d + FINE_W'(filt[i]);
        end
        sat_d = (fine_d == FINE_W'(N_TAPS));
    end
`else
    always_comb begin
        // scan downwards so the lowest zero wins
        fine_d = FINE_W'(N_TAPS);
        for (int i = N_TAPS - 1; i >= 0; i--) begin
            if (!s2_i[i]) fine_d = FINE_W'(i);
        end
        sat_d = (fine_d == FINE_W'(N_TAPS));
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_o  <= 1'b0;
            fine_o <= '0;
        end else begin
            sat_o  <= sat_d;
            fine_o <= fine_d;
        end
    end

endmodule

// File: rtl/tdc_channel_capture.sv
// tdc_channel_capture: one TDC channel. Samples the delay-line taps every
// cycle, detects new hit edges on tap 0, encodes a {SAT, COARSE, FINE}
// timestamp and queues it in an output FIFO with a valid/ready handshake.
// Sample-to-TS_VALID latency is 3 cycles.
// Optional macro: BUBBLE_FIX_EN (bubble-tolerant fine encoding, see encoder).
// Ports:
//   CLK      : clock
//   RST      : synchronous active-high reset, discards all events
//   TAPS     : asynchronous delay-line taps, bit 0 nearest to HIT
//   CLR_OVF  : pulse clearing OVERFLOW and DROP_CNT
//   TS_DATA  : FIFO head timestamp (0 when empty)
//   TS_VALID : FIFO not empty
//   TS_READY : consumer accepts TS_DATA
//   OVERFLOW : sticky, an event was dropped on a full FIFO
//   DROP_CNT : saturating dropped-event count
module tdc_channel_capture
    import tdc_pkg::*;
#(
    parameter int N_TAPS      = 32,
    parameter int COARSE_W    = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [N_TAPS-1:0]                 TAPS,
    input  logic                              CLR_OVF,
    output logic [ts_w(N_TAPS, COARSE_W)-1:0] TS_DATA,
    output logic                              TS_VALID,
    input  logic                              TS_READY,
    output logic                              OVERFLOW,
    output logic [DROP_CNT_W-1:0]             DROP_CNT
);

    localparam int FINE_W = fine_w(N_TAPS);
    localparam int TS_W   = ts_w(N_TAPS, COARSE_W);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 2);

    logic [COARSE_W-1:0]   coarse_q;
    logic [N_TAPS-1:0]     s1_q, s2_q;
    logic [COARSE_W-1:0]   s1_coarse_q, s2_coarse_q, enc_coarse_q;
    logic                  p0_q;
    logic [DEAD_W-1:0]     dead_q, dead_d;
    logic                  event_d, enc_ev_q;
    logic                  enc_sat;
    logic [FINE_W-1:0]     enc_fine;

    logic [TS_W-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  full, empty, do_rd, do_wr, drop;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    // Only tap 0 of the previous word is needed for edge detection.
    assign event_d = s2_q[0] & ~p0_q & (dead_q == '0);

    always_comb begin
        dead_d = dead_q;
        if (event_d)            dead_d = DEAD_W'(DEAD_CYCLES);
        else if (dead_q != '0)  dead_d = dead_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            coarse_q     <= '0;
            s1_q         <= '0;
            s1_coarse_q  <= '0;
            s2_q         <= '0;
            s2_coarse_q  <= '0;
            p0_q         <= 1'b0;
            dead_q       <= '0;
            enc_ev_q     <= 1'b0;
            enc_coarse_q <= '0;
        end else begin
            coarse_q     <= coarse_q + 1'b1;
            s1_q         <= TAPS;
            s1_coarse_q  <= coarse_q;
            s2_q         <= s1_q;
            s2_coarse_q  <= s1_coarse_q;
            p0_q         <= s2_q[0];
            dead_q       <= dead_d;
            enc_ev_q     <= event_d;
            enc_coarse_q <= s2_coarse_q;
        end
    end

    tdc_thermo_encoder #(
        .N_TAPS (N_TAPS)
    ) u_enc (
        .clk_i  (CLK),
        .rst_i  (RST),
        .s2_i   (s2_q),
        .sat_o  (enc_sat),
        .fine_o (enc_fine)
    );

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign do_rd = !empty && TS_READY;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr = enc_ev_q && (!full || do_rd);
    assign drop  = enc_ev_q && full && !do_rd;
    assign cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (CLR_OVF) begin
            ovf_d  = drop;
            drop_d = drop ? DROP_CNT_W'(1) : '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem_q[wr_ptr_q] <= {enc_sat, enc_coarse_q, enc_fine};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign TS_VALID = !empty;
    assign TS_DATA  = empty ? '0 : mem_q[rd_ptr_q];
    assign OVERFLOW = ovf_q;
    assign DROP_CNT = drop_q;

endmodule

// File: doc/tdc_channel_capture.md
Name: tdc_channel_capture

Overview:
Parametrised successor to the team's 4-tap delay-line sampler. It samples an N_TAPS tapped-delay-line vector on every CLK and detects new HIT edges. Each edge is encoded to a fine time (thermometer-to-binary) and combined with a free-running coarse counter into a timestamp. Timestamps are buffered in an output FIFO with a valid/ready handshake. One instance per TDC channel, between the carry-chain delay line and the channel readout mux.

Parameters:
N_TAPS, 32, number of delay-line taps sampled (must be >= 4; delay-line length must cover one CLK period)
COARSE_W, 16, coarse counter width in bits
FIFO_DEPTH, 8, output FIFO entries (power of 2, >= 2)
DEAD_CYCLES, 2, cycles after an accepted hit during which new edges are ignored (0 = none)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous active-high reset
TAPS  in  N_TAPS  asynchronous delay-line tap outputs; TAPS[0] is nearest to HIT
CLR_OVF  in  1  one-cycle pulse that clears OVERFLOW
TS_DATA  out  1+COARSE_W+FINE_W  timestamp {SAT, COARSE, FINE}; FINE_W = clog2(N_TAPS+1)
TS_VALID  out  1  FIFO not empty
TS_READY  in  1  consumer accepts TS_DATA when TS_VALID&&TS_READY
OVERFLOW  out  1  sticky: an event was dropped because the FIFO was full
DROP_CNT  out  8  saturating count of dropped events

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: S1, S2 and encode stage = 0; coarse counter = 0; FIFO empty; TS_VALID = 0; TS_DATA = 0; OVERFLOW = 0; DROP_CNT = 0; dead-time counter = 0. RST mid-operation discards all buffered and in-flight events.
- Coarse counter: +1 every cycle and wraps modulo 2^COARSE_W. The value present when TAPS is captured into S1 travels with the sample.
- Pipeline:
  - cycle k: TAPS -> S1 (metastability stage).
  - k+1: S1 -> S2; the previous S2 word is kept as P.
  - k+2: detect/encode register.
  - k+3: FIFO write; TS_VALID rises the same cycle if the FIFO was empty.
  - Fixed latency from sample to TS_VALID: 3 cycles.
- Detection: event when S2[0]=1, P[0]=0 and the dead-time counter is 0.
  - On an event, the dead-time counter loads DEAD_CYCLES and decrements to 0.
  - Edges during dead time are ignored and are not counted as drops.
- Fine encoding: FINE = position of the first 0 in S2, scanning from bit 0 (number of leading ones).
  - S2 all ones: FINE = N_TAPS and SAT = 1 (delay line too short).
  - Otherwise SAT = 0.
- Event timing: events are generated at most once per cycle. Back-to-back events (DEAD_CYCLES=0) with alternating TAPS[0] produce one event every 2 cycles.
- FIFO:
  - Write on event when not full.
  - Read on TS_VALID&&TS_READY.
  - Simultaneous read and write when full: the write is accepted and no drop occurs.
  - Simultaneous read and write when empty: the write is stored and the read is ignored, since TS_VALID was 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - TS_DATA shows the head entry and holds stable while TS_VALID && !TS_READY.
- Drops: an event when full and no read in the same cycle is dropped.
  - OVERFLOW is set; DROP_CNT increments and saturates at 255.
  - CLR_OVF clears OVERFLOW and DROP_CNT. If CLR_OVF coincides with a drop, the result is OVERFLOW=1 and DROP_CNT=1.

Optional Feature:
BUBBLE_FIX_EN
- Defined: S2 first passes through a 3-tap majority filter: bit i = maj(S2[i-1], S2[i], S2[i+1]), with edge bits replicated. FINE is then computed as the population count of the filtered word, which tolerates single-bit bubbles. Latency is unchanged because the filter sits in the encode stage.
- Not defined: plain leading-ones encoding as described above; any bubble truncates FINE at the bubble.

Decomposition:
- Package tdc_pkg holds:
  - FINE_W/TS_W width functions (clog2);
  - the timestamp field offsets (SAT, COARSE, FINE);
  - the DROP_CNT width constant.
- One sub-module, tdc_thermo_encoder (combinational plus output register): S2 -> {SAT, FINE}, containing the BUBBLE_FIX_EN logic.
- The FIFO is inline in this module.

Test Plan:
1. Reset, then TAPS=0x0000_00FF held 1 cycle after 0 (N_TAPS=32) -> after 3 cycles TS_VALID=1, FINE=8, SAT=0, COARSE = counter value at the sample cycle.
2. TAPS=0xFFFF_FFFF after 0 -> FINE=32, SAT=1.
3. TS_READY=0, 9 events spaced beyond dead time, FIFO_DEPTH=8 -> 8 stored in order, OVERFLOW=1, DROP_CNT=1; CLR_OVF pulse -> both 0.
4. DEAD_CYCLES=2, edges at cycles 0, 2 and 4 -> events at cycles 0 and 4 only; DROP_CNT stays 0.
5. Coarse counter near wrap (COARSE_W=4): event at count 15 then event at count 1 -> COARSE=15 then COARSE=1.
6. BUBBLE_FIX_EN defined, TAPS=0x0000_00F7 -> FINE=8; not defined -> FINE=3. Additionally assert RST while the FIFO holds 3 entries -> TS_VALID=0 the next cycle.
